// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one external memory port between instruction fetch and the LSU
//   data path. Three-way round-robin (fetch read, data read, data write),
//   one outstanding read at a time, writes issued as single-cycle posted
//   pulses. Read responses are routed back to their owner; a fetch response
//   can be dropped by i_kill.
//
//   Ports:
//     clk, rst                         clock, synchronous active-high reset
//     i_ren/i_raddr -> i_ready         fetch read request / accept
//     i_rvalid/i_rdata                 fetch response
//     i_kill                           drop pending/arriving fetch response
//     d_ren/d_raddr -> d_rready        data read request / accept
//     d_rvalid/d_rdata                 data read response
//     d_wen/d_waddr/d_wdata -> d_wready data write request / accept
//     mem_ren/mem_raddr, mem_rvalid/mem_rdata   memory read port
//     mem_wen/mem_waddr/mem_wdata      memory write port
//
//   Optional: define MEM_ARB_STATS_EN to add the statistics counters
//   stat_i_grants, stat_d_rgrants, stat_d_wgrants, stat_conflict_cycles.
//
//   state | meaning
//   IDLE  | arbitrating; grants at most one request per cycle
//   RD_I  | fetch read outstanding on the memory port
//   RD_D  | data read outstanding on the memory port
//   WR    | posted write pulse on the memory port
module mem_port_arbiter #(
  parameter int ADDR_BITS = 64,
  parameter int DATA_BITS = 64,
  parameter int CNT_BITS  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_ren,
  input  logic [ADDR_BITS-1:0] i_raddr,
  output logic                 i_ready,
  output logic                 i_rvalid,
  output logic [DATA_BITS-1:0] i_rdata,
  input  logic                 i_kill,
  input  logic                 d_ren,
  input  logic [ADDR_BITS-1:0] d_raddr,
  output logic                 d_rready,
  output logic                 d_rvalid,
  output logic [DATA_BITS-1:0] d_rdata,
  input  logic                 d_wen,
  input  logic [ADDR_BITS-1:0] d_waddr,
  input  logic [DATA_BITS-1:0] d_wdata,
  output logic                 d_wready,
  output logic                 mem_ren,
  output logic [ADDR_BITS-1:0] mem_raddr,
  input  logic                 mem_rvalid,
  input  logic [DATA_BITS-1:0] mem_rdata,
  output logic                 mem_wen,
  output logic [ADDR_BITS-1:0] mem_waddr,
  output logic [DATA_BITS-1:0] mem_wdata
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [CNT_BITS-1:0]  stat_i_grants,
  output logic [CNT_BITS-1:0]  stat_d_rgrants,
  output logic [CNT_BITS-1:0]  stat_d_wgrants,
  output logic [CNT_BITS-1:0]  stat_conflict_cycles
`endif
);

  typedef enum logic [1:0] {IDLE, RD_I, RD_D, WR} state_t;
  typedef enum logic [1:0] {FETCH, DREAD, DWRITE} cls_t;

  state_t state, state_nx;
  cls_t   rr_ptr, rr_nx;
  logic   kill_flag, kill_nx;

  logic [ADDR_BITS-1:0] raddr_q, waddr_q;
  logic [DATA_BITS-1:0] wdata_q, i_rdata_q, d_rdata_q;

  logic [2:0] req;
  logic       grant_any;
  cls_t       winner;

  assign req = {d_wen, d_ren, i_ren};

  function automatic cls_t next_cls(input cls_t c);
    case (c)
      FETCH:   next_cls = DREAD;
      DREAD:   next_cls = DWRITE;
      default: next_cls = FETCH;
    endcase
  endfunction

  // Scan three classes starting at rr_ptr; first active request wins.
  always_comb begin : arb
    cls_t cand;
    grant_any = 1'b0;
    winner    = FETCH;
    cand      = rr_ptr;
    for (int k = 0; k < 3; k++) begin
      if (!grant_any && req[cand]) begin
        winner    = cand;
        grant_any = 1'b1;
      end
      cand = next_cls(cand);
    end
  end

  always_comb begin
    state_nx  = state;
    rr_nx     = rr_ptr;
    kill_nx   = kill_flag;
    i_ready   = 1'b0;
    d_rready  = 1'b0;
    d_wready  = 1'b0;
    i_rvalid  = 1'b0;
    d_rvalid  = 1'b0;
    mem_ren   = 1'b0;
    mem_wen   = 1'b0;
    case (state)
      IDLE: begin
        if (grant_any) begin
          rr_nx = next_cls(winner);
          case (winner)
            FETCH:   begin i_ready  = 1'b1; state_nx = RD_I; end
            DREAD:   begin d_rready = 1'b1; state_nx = RD_D; end
            default: begin d_wready = 1'b1; state_nx = WR;   end
          endcase
        end
      end
      RD_I: begin
        mem_ren = 1'b1;
        if (mem_rvalid) begin
          i_rvalid = !(kill_flag | i_kill);
          state_nx = IDLE;
          kill_nx  = 1'b0;
        end else if (i_kill) begin
          kill_nx = 1'b1;
        end
      end
      RD_D: begin
        mem_ren = 1'b1;
        if (mem_rvalid) begin
          d_rvalid = 1'b1;
          state_nx = IDLE;
          kill_nx  = 1'b0;
        end
      end
      default: begin
        mem_wen  = 1'b1;
        state_nx = IDLE;
        kill_nx  = 1'b0;
      end
    endcase
    // Outputs are quiet during reset even though state has not yet cleared.
    if (rst) begin
      i_ready  = 1'b0;
      d_rready = 1'b0;
      d_wready = 1'b0;
      i_rvalid = 1'b0;
      d_rvalid = 1'b0;
      mem_ren  = 1'b0;
      mem_wen  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= FETCH;
      kill_flag <= 1'b0;
      raddr_q   <= '0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state     <= state_nx;
      rr_ptr    <= rr_nx;
      kill_flag <= kill_nx;
      if (i_ready)  raddr_q <= i_raddr;
      if (d_rready) raddr_q <= d_raddr;
      if (d_wready) begin
        waddr_q <= d_waddr;
        wdata_q <= d_wdata;
      end
      if (i_rvalid) i_rdata_q <= mem_rdata;
      if (d_rvalid) d_rdata_q <= mem_rdata;
    end
  end

  // Response buses pass memory data through in the valid cycle, else hold.
  assign i_rdata   = i_rvalid ? mem_rdata : i_rdata_q;
  assign d_rdata   = d_rvalid ? mem_rdata : d_rdata_q;
  assign mem_raddr = raddr_q;
  assign mem_waddr = waddr_q;
  assign mem_wdata = wdata_q;

`ifdef MEM_ARB_STATS_EN
  logic [1:0] n_req;
  logic       conflict;

  assign n_req    = {1'b0, i_ren} + {1'b0, d_ren} + {1'b0, d_wen};
  assign conflict = (state == IDLE) ? (n_req >= 2'd2) : (n_req != 2'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_i_grants        <= '0;
      stat_d_rgrants       <= '0;
      stat_d_wgrants       <= '0;
      stat_conflict_cycles <= '0;
    end else begin
      if (i_ready)  stat_i_grants        <= stat_i_grants + 1'b1;
      if (d_rready) stat_d_rgrants       <= stat_d_rgrants + 1'b1;
      if (d_wready) stat_d_wgrants       <= stat_d_wgrants + 1'b1;
      if (conflict) stat_conflict_cycles <= stat_conflict_cycles + 1'b1;
    end
  end
`endif

endmodule
